// File: rtl/circuito_autenticador_sequencial.sv
// Sequential code authenticator: collects N_DIGITS digits, compares them with CODE_REF
// and pulses grant/deny. Define AUT_LOCKOUT_EN to add the timed lockout after MAX_TRIES failures.
module circuito_autenticador_sequencial #(
  parameter int DIGIT_W     = 4,
  parameter int N_DIGITS    = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic [DIGIT_W-1:0]                DIGIT_IN,
  input  logic                              DIGIT_VALID,
  input  logic                              CLEAR,
  input  logic [N_DIGITS*DIGIT_W-1:0]       CODE_REF,
  output logic                              AUT1,
  output logic                              AUT2,
  output logic                              AUT3,
  output logic [$clog2(N_DIGITS+1)-1:0]     DIGIT_CNT,
  output logic [$clog2(MAX_TRIES+1)-1:0]    TRIES_LEFT
);

  localparam int CODE_W  = N_DIGITS * DIGIT_W;
  localparam int CNT_W   = $clog2(N_DIGITS + 1);
  localparam int TRIES_W = $clog2(MAX_TRIES + 1);

  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    CHECK,
    GRANT,
    DENY
`ifdef AUT_LOCKOUT_EN
    ,
    LOCKED
`endif
  } state_t;

  state_t               state_q;
  logic [CODE_W-1:0]    code_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [TRIES_W-1:0]   tries_q;
  logic [TRIES_W-1:0]   tries_dec;
  logic                 aut1_q;
  logic                 aut2_q;

  // Saturating decrement keeps the counter at zero when no lockout ever reloads it
  assign tries_dec = (tries_q == '0) ? '0 : tries_q - TRIES_W'(1);

`ifdef AUT_LOCKOUT_EN
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  logic [LOCK_W-1:0]    lock_q;
  logic                 aut3_q;
  assign AUT3 = aut3_q;
`else
  assign AUT3 = 1'b0;
`endif

  assign AUT1       = aut1_q;
  assign AUT2       = aut2_q;
  assign DIGIT_CNT  = cnt_q;
  assign TRIES_LEFT = tries_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      code_q  <= '0;
      cnt_q   <= '0;
      tries_q <= TRIES_W'(MAX_TRIES);
      aut1_q  <= 1'b0;
      aut2_q  <= 1'b0;
`ifdef AUT_LOCKOUT_EN
      lock_q  <= '0;
      aut3_q  <= 1'b0;
`endif
    end else begin
      aut1_q <= 1'b0;
      aut2_q <= 1'b0;
      case (state_q)
        IDLE, ENTRY: begin
          if (CLEAR) begin
            cnt_q   <= '0;
            code_q  <= '0;
            state_q <= IDLE;
          end else if (DIGIT_VALID) begin
            code_q  <= (code_q << DIGIT_W) | CODE_W'(DIGIT_IN);
            cnt_q   <= cnt_q + CNT_W'(1);
            state_q <= (cnt_q == CNT_W'(N_DIGITS - 1)) ? CHECK : ENTRY;
          end
        end
        CHECK: begin
          state_q <= (code_q == CODE_REF) ? GRANT : DENY;
        end
        GRANT: begin
          aut1_q  <= 1'b1;
          tries_q <= TRIES_W'(MAX_TRIES);
          cnt_q   <= '0;
          code_q  <= '0;
          state_q <= IDLE;
        end
        DENY: begin
          aut2_q  <= 1'b1;
          tries_q <= tries_dec;
          cnt_q   <= '0;
          code_q  <= '0;
`ifdef AUT_LOCKOUT_EN
          state_q <= (tries_dec == '0) ? LOCKED : IDLE;
`else
          state_q <= IDLE;
`endif
        end
`ifdef AUT_LOCKOUT_EN
        // AUT3 rises one edge after the deny pulse so the two never overlap
        LOCKED: begin
          if (lock_q == LOCK_W'(LOCK_CYCLES)) begin
            aut3_q  <= 1'b0;
            lock_q  <= '0;
            tries_q <= TRIES_W'(MAX_TRIES);
            state_q <= IDLE;
          end else begin
            aut3_q <= 1'b1;
            lock_q <= lock_q + LOCK_W'(1);
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_circuito_autenticador_sequencial.sv
// Bench for circuito_autenticador_sequencial: vector table, hand sequences and random
// stimulus against a schedule-based reference model (lockout checks follow AUT_LOCKOUT_EN).
module tb_circuito_autenticador_sequencial;

  localparam int DW = 4;
  localparam int ND = 4;
  localparam int MT = 3;
  localparam int LC = 16;
`ifdef AUT_LOCKOUT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [3:0]  DIGIT_IN = '0;
  logic        DIGIT_VALID = 1'b0;
  logic        CLEAR = 1'b0;
  logic [15:0] CODE_REF = 16'h1234;
  logic        AUT1, AUT2, AUT3;
  logic [2:0]  DIGIT_CNT;
  logic [1:0]  TRIES_LEFT;

  circuito_autenticador_sequencial #(
    .DIGIT_W(DW), .N_DIGITS(ND), .MAX_TRIES(MT), .LOCK_CYCLES(LC)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .DIGIT_IN(DIGIT_IN), .DIGIT_VALID(DIGIT_VALID),
    .CLEAR(CLEAR), .CODE_REF(CODE_REF), .AUT1(AUT1), .AUT2(AUT2), .AUT3(AUT3),
    .DIGIT_CNT(DIGIT_CNT), .TRIES_LEFT(TRIES_LEFT)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_total = 0;
  int cnt_a1 = 0, cnt_a2 = 0, cnt_a3 = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: entered digits kept as a list, verdict and lockout as scheduled edge numbers
  int m_dig[$];
  int m_tries;
  bit m_pend, m_match, m_locked;
  int m_vedge, m_lstart;
  int edge_n = 0;
  bit e_a1, e_a2, e_a3;

  function automatic int code_of();
    int r = 0;
    foreach (m_dig[i]) r = r * 16 + m_dig[i];
    return r;
  endfunction

  task automatic model_reset();
    m_dig.delete();
    m_tries = MT; m_pend = 0; m_locked = 0; m_match = 0;
    e_a1 = 0; e_a2 = 0; e_a3 = 0;
  endtask

  task automatic model_edge(input bit dv, input int d, input bit clr, input int refv);
    edge_n++;
    e_a1 = 0; e_a2 = 0;
    if (m_pend) begin
      if (edge_n == m_vedge - 1) m_match = (code_of() == refv);
      else begin
        m_pend = 0;
        m_dig.delete();
        if (m_match) begin
          e_a1 = 1; m_tries = MT;
        end else begin
          e_a2 = 1;
          m_tries = (m_tries > 0) ? m_tries - 1 : 0;
          if (LOCK_EN && m_tries == 0) begin
            m_locked = 1; m_lstart = edge_n + 1;
          end
        end
      end
    end else if (m_locked) begin
      if (edge_n == m_lstart + LC) begin
        e_a3 = 0; m_tries = MT; m_locked = 0;
      end else e_a3 = 1;
    end else if (clr) m_dig.delete();
    else if (dv) begin
      m_dig.push_back(d);
      if (m_dig.size() == ND) begin
        m_pend = 1; m_vedge = edge_n + 2;
      end
    end
  endtask

  task automatic cycle(input bit dv, input int d, input bit clr);
    DIGIT_VALID = dv; DIGIT_IN = 4'(d); CLEAR = clr;
    @(posedge CLK);
    model_edge(dv, d, clr, int'(CODE_REF));
    #1;
    if (AUT1) cnt_a1++;
    if (AUT2) cnt_a2++;
    if (AUT3) cnt_a3++;
    check("AUT1", int'(AUT1), int'(e_a1));
    check("AUT2", int'(AUT2), int'(e_a2));
    check("AUT3", int'(AUT3), int'(e_a3));
    check("DIGIT_CNT", int'(DIGIT_CNT), m_dig.size());
    check("TRIES_LEFT", int'(TRIES_LEFT), m_tries);
    check("mutex", int'(AUT1) + int'(AUT2) + int'(AUT3) <= 1 ? 1 : 0, 1);
  endtask

  task automatic do_reset();
    RST_N = 1'b0; DIGIT_VALID = 0; CLEAR = 0;
    #1;
    check("rst_AUT1", int'(AUT1), 0);
    check("rst_AUT2", int'(AUT2), 0);
    check("rst_AUT3", int'(AUT3), 0);
    check("rst_DIGIT_CNT", int'(DIGIT_CNT), 0);
    check("rst_TRIES_LEFT", int'(TRIES_LEFT), MT);
    model_reset();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  task automatic enter_code(input logic [15:0] c);
    logic [15:0] v;
    v = c;
    for (int i = 0; i < ND; i++) cycle(1, int'(v[15-4*i -: 4]), 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0);
  endtask

  typedef struct {
    bit dv; int d; bit clr; bit a1; bit a2; int cnt; int tries;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit dv, input int d, input bit clr,
                     input bit a1, input bit a2, input int cnt, input int tries);
    vec_t v;
    v.dv = dv; v.d = d; v.clr = clr; v.a1 = a1; v.a2 = a2; v.cnt = cnt; v.tries = tries;
    tbl.push_back(v);
  endtask

  initial begin
    int a1_0, a2_0, a3_0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    do_reset();

    // Correct code, wrong code, correct code, then clear-with-digit and ignored inputs
    add(1,1,0,0,0,1,3); add(1,2,0,0,0,2,3); add(1,3,0,0,0,3,3); add(1,4,0,0,0,4,3);
    add(0,0,0,0,0,4,3); add(0,0,0,1,0,0,3); add(0,0,0,0,0,0,3);
    add(1,1,0,0,0,1,3); add(1,2,0,0,0,2,3); add(1,3,0,0,0,3,3); add(1,5,0,0,0,4,3);
    add(0,0,0,0,0,4,3); add(0,0,0,0,1,0,2); add(0,0,0,0,0,0,2);
    add(1,1,0,0,0,1,2); add(1,2,0,0,0,2,2); add(1,3,0,0,0,3,2); add(1,4,0,0,0,4,2);
    add(0,0,0,0,0,4,2); add(0,0,0,1,0,0,3); add(0,0,0,0,0,0,3);
    add(1,1,0,0,0,1,3); add(1,2,0,0,0,2,3); add(1,3,1,0,0,0,3);
    add(1,1,0,0,0,1,3); add(1,2,0,0,0,2,3); add(1,3,0,0,0,3,3); add(1,4,0,0,0,4,3);
    add(0,0,1,0,0,4,3); add(1,7,0,1,0,0,3); add(0,0,0,0,0,0,3);
    foreach (tbl[i]) begin
      cycle(tbl[i].dv, tbl[i].d, tbl[i].clr);
      check($sformatf("tbl%0d_AUT1", i), int'(AUT1), int'(tbl[i].a1));
      check($sformatf("tbl%0d_AUT2", i), int'(AUT2), int'(tbl[i].a2));
      check($sformatf("tbl%0d_CNT", i), int'(DIGIT_CNT), tbl[i].cnt);
      check($sformatf("tbl%0d_TRIES", i), int'(TRIES_LEFT), tbl[i].tries);
    end

    // Reset after two digits: nothing pending survives, first digit after release counts
    cycle(1, 1, 0); cycle(1, 2, 0);
    a1_0 = cnt_a1; a2_0 = cnt_a2;
    do_reset();
    cycle(1, 1, 0);
    check("post_rst_first_digit", int'(DIGIT_CNT), 1);
    cycle(0, 0, 1);
    repeat (4) cycle(0, 0, 0);
    check("rst_no_pulse", (cnt_a1 - a1_0) + (cnt_a2 - a2_0), 0);

    if (LOCK_EN) begin
      a2_0 = cnt_a2; a3_0 = cnt_a3;
      enter_code(16'h1111); enter_code(16'h2222); enter_code(16'h3333);
      for (int k = 0; k < 16; k++) cycle(1, (k % 4) + 1, 0);
      repeat (4) cycle(0, 0, 0);
      check("lock_deny_pulses", cnt_a2 - a2_0, 3);
      check("lock_aut3_cycles", cnt_a3 - a3_0, LC);
      check("lock_digits_ignored", int'(DIGIT_CNT), 0);
      check("lock_tries_after", int'(TRIES_LEFT), MT);
      a1_0 = cnt_a1;
      enter_code(16'h1234);
      check("lock_grant_after", cnt_a1 - a1_0, 1);
      enter_code(16'h9999); enter_code(16'h9999); enter_code(16'h9999);
      repeat (5) cycle(0, 0, 0);
      check("midlock_aut3_high", int'(AUT3), 1);
      do_reset();
      repeat (3) cycle(0, 0, 0);
      check("midlock_tries", int'(TRIES_LEFT), MT);
    end else begin
      a2_0 = cnt_a2;
      for (int k = 0; k < 4; k++) enter_code(16'h4321);
      check("nolock_deny_pulses", cnt_a2 - a2_0, 4);
      check("nolock_tries_zero", int'(TRIES_LEFT), 0);
      check("nolock_aut3_never", cnt_a3, 0);
      enter_code(16'h1234);
      check("nolock_tries_reload", int'(TRIES_LEFT), MT);
      enter_code(16'h0000);
      do_reset();
      check("nolock_rst_tries", int'(TRIES_LEFT), MT);
    end

    // Random traffic, biased toward correct digits so grants occur
    for (int k = 0; k < 400; k++) begin
      bit dv, clr;
      int d;
      dv  = ($urandom_range(0, 1) == 1);
      clr = ($urandom_range(0, 15) == 0);
      d   = ($urandom_range(0, 3) != 0 && m_dig.size() < ND) ? m_dig.size() + 1
                                                           : int'($urandom_range(0, 15));
      cycle(dv, d, clr);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/circuito_autenticador_sequencial.md
CIRCUITO_AUTENTICADOR_SEQUENCIAL -- requirements
Module: circuito_autenticador_sequencial

Interface
REQ-001 Parameter DIGIT_W, default 4, bits per entered digit.
REQ-002 Parameter N_DIGITS, default 4, digits per code.
REQ-003 Parameter MAX_TRIES, default 3, consecutive failures allowed before lockout.
REQ-004 Parameter LOCK_CYCLES, default 16, lockout duration in clock cycles.
REQ-005 CLK  in  1  single clock; all state updates on rising edge.
REQ-006 RST_N  in  1  reset, asynchronous assert, active-low.
REQ-007 DIGIT_IN  in  DIGIT_W  digit value, sampled when DIGIT_VALID=1.
REQ-008 DIGIT_VALID  in  1  one-cycle strobe qualifying DIGIT_IN.
REQ-009 CLEAR  in  1  abort partial entry.
REQ-010 CODE_REF  in  N_DIGITS*DIGIT_W  stored code; first digit is the most significant field.
REQ-011 AUT1  out  1  access-granted pulse.
REQ-012 AUT2  out  1  access-denied pulse.
REQ-013 AUT3  out  1  locked-out level.
REQ-014 DIGIT_CNT  out  $clog2(N_DIGITS+1)  digits accepted in current entry.
REQ-015 TRIES_LEFT  out  $clog2(MAX_TRIES+1)  failures remaining before lockout.

Function
REQ-016 The FSM SHALL have states IDLE, ENTRY, CHECK, GRANT, DENY, LOCKED.
REQ-017 In IDLE/ENTRY a DIGIT_VALID cycle SHALL shift DIGIT_IN into the code register's LSB field and increment DIGIT_CNT; IDLE->ENTRY on the first digit.
REQ-018 The edge accepting digit N_DIGITS SHALL move the FSM to CHECK; DIGIT_CNT then reads N_DIGITS.
REQ-019 CHECK SHALL last exactly one cycle, comparing the full entered code with CODE_REF sampled that cycle; match->GRANT, mismatch->DENY.
REQ-020 AUT1 (GRANT) or AUT2 (DENY) SHALL be high for exactly one cycle, starting two rising edges after the edge accepting the last digit.
REQ-021 GRANT SHALL reload TRIES_LEFT to MAX_TRIES, clear DIGIT_CNT, and return to IDLE.
REQ-022 DENY SHALL decrement TRIES_LEFT and clear DIGIT_CNT; next state LOCKED if TRIES_LEFT becomes 0 (lockout enabled), else IDLE.
REQ-023 DIGIT_VALID SHALL be ignored in CHECK, GRANT, DENY, LOCKED; ignored digits are lost, not queued.
REQ-024 CLEAR in IDLE/ENTRY SHALL zero DIGIT_CNT and the code register and go to IDLE, TRIES_LEFT unchanged; CLEAR wins over a simultaneous DIGIT_VALID.
REQ-025 CLEAR SHALL be ignored in CHECK, GRANT, DENY, LOCKED.
REQ-026 LOCKED SHALL hold AUT3=1 for exactly LOCK_CYCLES cycles, then reload TRIES_LEFT to MAX_TRIES, deassert AUT3, enter IDLE.
REQ-027 AUT1, AUT2, AUT3 SHALL be registered outputs, mutually exclusive in every cycle.

Reset
REQ-028 RST_N=0 SHALL immediately force state IDLE, AUT1=AUT2=AUT3=0, DIGIT_CNT=0, code register 0, lock counter 0, TRIES_LEFT=MAX_TRIES.
REQ-029 Reset in any state, including mid-entry or mid-lockout, SHALL abandon the operation with no pulse emitted; first digit accepted on the first edge after RST_N rises.

Configuration
REQ-030 Macro AUT_LOCKOUT_EN defined: behaviour per REQ-022 and REQ-026.
REQ-031 AUT_LOCKOUT_EN undefined: LOCKED state and lock counter absent, DENY always returns to IDLE, AUT3 tied 0, TRIES_LEFT saturates at 0 and reloads only on GRANT or reset.

Verification (DIGIT_W=4, N_DIGITS=4, MAX_TRIES=3, LOCK_CYCLES=16, CODE_REF=16'h1234)
REQ-032 Digits 1,2,3,4 on consecutive cycles -> AUT1 one cycle, two edges after digit 4; TRIES_LEFT=3.
REQ-033 Digits 1,2,3,5 -> AUT2 one cycle, TRIES_LEFT=2; then 1,2,3,4 -> AUT1, TRIES_LEFT=3.
REQ-034 Digits 1,2, CLEAR with DIGIT_VALID=1/DIGIT_IN=3 same cycle, then 1,2,3,4 -> DIGIT_CNT 0 after CLEAR, AUT1 pulse, TRIES_LEFT=3.
REQ-035 Three wrong codes (with AUT_LOCKOUT_EN) -> AUT2 on third, AUT3 high 16 cycles, digits 1,2,3,4 during lockout ignored, TRIES_LEFT=3 after exit.
REQ-036 RST_N pulsed low after digits 1,2 and again mid-lockout -> outputs zero asynchronously, DIGIT_CNT=0, no AUT1/AUT2 pulse, TRIES_LEFT=3.
REQ-037 Without AUT_LOCKOUT_EN, four wrong codes -> four AUT2 pulses, AUT3 constant 0, TRIES_LEFT=0.
